// File: rtl/udp_rx_port_dispatch.sv
// UDP RX port dispatcher: routes each received UDP packet to the
// sink whose configured port matches the destination port, or drops it.
module udp_rx_port_dispatch #(
  parameter int N_SINKS    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_hdr_valid,
  output logic                    s_hdr_ready,
  input  logic [31:0]             s_ip_source_ip,
  input  logic [15:0]             s_source_port,
  input  logic [15:0]             s_dest_port,
  input  logic [15:0]             s_length,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  input  logic [16*N_SINKS-1:0]   cfg_port,
  input  logic [N_SINKS-1:0]      cfg_enable,
  output logic [N_SINKS-1:0]      m_hdr_valid,
  input  logic [N_SINKS-1:0]      m_hdr_ready,
  output logic [31:0]             m_ip_source_ip,
  output logic [15:0]             m_source_port,
  output logic [15:0]             m_dest_port,
  output logic [15:0]             m_length,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [N_SINKS-1:0]      m_tvalid,
  output logic                    m_tlast,
  input  logic [N_SINKS-1:0]      m_tready,
  output logic [31:0]             drop_count,
  output logic                    busy
);

  localparam int SEL_W = (N_SINKS > 1) ? $clog2(N_SINKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic             match_hit;
  logic [SEL_W-1:0] match_idx;

  // Scan from the top so the lowest matching index is the last to win.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = N_SINKS - 1; i >= 0; i--) begin
      if (cfg_enable[i] && (cfg_port[16*i +: 16] == s_dest_port)) begin
        match_hit = 1'b1;
        match_idx = i[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      sel            <= '0;
      m_ip_source_ip <= '0;
      m_source_port  <= '0;
      m_dest_port    <= '0;
      m_length       <= '0;
      drop_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s_hdr_valid) begin
            m_ip_source_ip <= s_ip_source_ip;
            m_source_port  <= s_source_port;
            m_dest_port    <= s_dest_port;
            m_length       <= s_length;
            sel            <= match_idx;
            state          <= match_hit ? HDR : DROP;
          end
        end
        HDR: begin
          if (m_hdr_ready[sel]) state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (s_tvalid && m_tready[sel] && s_tlast) state <= IDLE;
        end
        DROP: begin
          if (s_tvalid && s_tlast) begin
            if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_hdr_ready = (state == IDLE);
    busy        = (state != IDLE);
    m_hdr_valid = '0;
    m_tvalid    = '0;
    s_tready    = 1'b0;
    m_tdata     = s_tdata;
    m_tlast     = s_tlast;
    unique case (state)
      IDLE: ;
      HDR: m_hdr_valid[sel] = 1'b1;
      PAYLOAD: begin
        m_tvalid[sel] = s_tvalid;
        s_tready      = m_tready[sel];
      end
      DROP: s_tready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_udp_rx_port_dispatch.sv
// Directed bench for udp_rx_port_dispatch: routing, drops, priority,
// backpressure, back-to-back headers and mid-packet reset.
module tb_udp_rx_port_dispatch;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_hdr_valid;
  logic          s_hdr_ready;
  logic [31:0]   s_ip_source_ip;
  logic [15:0]   s_source_port;
  logic [15:0]   s_dest_port;
  logic [15:0]   s_length;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [16*N-1:0] cfg_port;
  logic [N-1:0]  cfg_enable;
  logic [N-1:0]  m_hdr_valid;
  logic [N-1:0]  m_hdr_ready;
  logic [31:0]   m_ip_source_ip;
  logic [15:0]   m_source_port;
  logic [15:0]   m_dest_port;
  logic [15:0]   m_length;
  logic [DW-1:0] m_tdata;
  logic [N-1:0]  m_tvalid;
  logic          m_tlast;
  logic [N-1:0]  m_tready;
  logic [31:0]   drop_count;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  udp_rx_port_dispatch #(.N_SINKS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_ip_source_ip(s_ip_source_ip), .s_source_port(s_source_port),
    .s_dest_port(s_dest_port), .s_length(s_length),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .cfg_port(cfg_port), .cfg_enable(cfg_enable),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_ip_source_ip(m_ip_source_ip), .m_source_port(m_source_port),
    .m_dest_port(m_dest_port), .m_length(m_length),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .drop_count(drop_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a header for one cycle; it is accepted at that edge (IDLE).
  task automatic send_hdr(input logic [15:0] dp, input logic [15:0] sp);
    s_hdr_valid    = 1'b1;
    s_dest_port    = dp;
    s_source_port  = sp;
    s_ip_source_ip = 32'hC0A8_0001;
    s_length       = 16'd12;
    tick();
    s_hdr_valid    = 1'b0;
    s_dest_port    = 16'h0;
    s_source_port  = 16'h0;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
  endtask

  task automatic idle_stream();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  initial begin
    int b;
    int rx;
    int cyc;
    logic [7:0] exp_d;

    reset = 1'b1;
    s_hdr_valid = 1'b0;
    s_ip_source_ip = '0;
    s_source_port = '0;
    s_dest_port = '0;
    s_length = '0;
    idle_stream();
    cfg_port = '0;
    cfg_enable = '0;
    m_hdr_ready = '0;
    m_tready = '0;

    #3;
    chk("rst_hdr_ready", 32'(s_hdr_ready), 32'd1);
    chk("rst_hdr_valid", 32'(m_hdr_valid), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", drop_count, 32'd0);
    chk("rst_dest", 32'(m_dest_port), 32'd0);
    tick();
    reset = 1'b0;

    // Single match to sink 1
    cfg_port = {16'h0000, 16'h0000, 16'h5678, 16'h1234};
    cfg_enable = 4'b0011;
    #1;
    chk("t1_idle_ready", 32'(s_hdr_ready), 32'd1);
    send_hdr(16'h5678, 16'h1111);
    chk("t1_hdr_valid", 32'(m_hdr_valid), 32'b0010);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_dest", 32'(m_dest_port), 32'h5678);
    chk("t1_ip", m_ip_source_ip, 32'hC0A8_0001);
    chk("t1_len", 32'(m_length), 32'd12);
    chk("t1_hdr_ready_lo", 32'(s_hdr_ready), 32'd0);
    m_hdr_ready = 4'b0010;
    tick();
    m_hdr_ready = 4'b0000;
    chk("t1_hdr_valid_drop", 32'(m_hdr_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      beat(8'hA0 + 8'(k), k == 3);
      m_tready = 4'b0011;
      #1;
      chk("t1_tvalid", 32'(m_tvalid), 32'b0010);
      chk("t1_tdata", 32'(m_tdata), 32'hA0 + 32'(k));
      chk("t1_tlast", 32'(m_tlast), (k == 3) ? 32'd1 : 32'd0);
      chk("t1_tready", 32'(s_tready), 32'd1);
      tick();
    end
    idle_stream();
    m_tready = '0;
    #1;
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_ready_end", 32'(s_hdr_ready), 32'd1);
    chk("t1_drop", drop_count, 32'd0);
    chk("t1_dest_hold", 32'(m_dest_port), 32'h5678);

    // Unmatched port is consumed and counted
    send_hdr(16'h9999, 16'h2222);
    chk("t2_hdr_valid", 32'(m_hdr_valid), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      beat(8'h10 + 8'(k), k == 2);
      #1;
      chk("t2_tready", 32'(s_tready), 32'd1);
      chk("t2_tvalid", 32'(m_tvalid), 32'd0);
      tick();
    end
    idle_stream();
    #1;
    chk("t2_drop", drop_count, 32'd1);
    chk("t2_busy_end", 32'(busy), 32'd0);

    // Lowest index wins; disabled entry never matches
    cfg_port = {16'h0000, 16'h0050, 16'h0000, 16'h0050};
    cfg_enable = 4'b0101;
    send_hdr(16'h0050, 16'h3333);
    chk("t3_prio", 32'(m_hdr_valid), 32'b0001);
    m_hdr_ready = 4'b0001;
    tick();
    m_hdr_ready = '0;
    beat(8'h55, 1'b1);
    m_tready = 4'b0001;
    tick();
    idle_stream();
    m_tready = '0;
    cfg_enable = 4'b0100;
    send_hdr(16'h0050, 16'h3333);
    cfg_enable = 4'b0000;
    #1;
    chk("t3_enable", 32'(m_hdr_valid), 32'b0100);
    chk("t3_cfg_frozen", 32'(busy), 32'd1);
    m_hdr_ready = 4'b0100;
    tick();
    m_hdr_ready = '0;
    beat(8'h66, 1'b1);
    m_tready = 4'b0100;
    #1;
    chk("t3_tvalid2", 32'(m_tvalid), 32'b0100);
    tick();
    idle_stream();
    m_tready = '0;
    #1;
    chk("t3_drop", drop_count, 32'd1);

    // Header and payload backpressure to sink 1
    cfg_port = {16'h0000, 16'h0000, 16'h5678, 16'h1234};
    cfg_enable = 4'b0011;
    send_hdr(16'h5678, 16'hBEEF);
    beat(8'hB0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_hdr_hold", 32'(m_hdr_valid), 32'b0010);
      chk("t4_sport", 32'(m_source_port), 32'hBEEF);
      chk("t4_tready_hdr", 32'(s_tready), 32'd0);
      tick();
    end
    m_hdr_ready = 4'b0010;
    tick();
    m_hdr_ready = '0;
    b = 0;
    rx = 0;
    cyc = 0;
    while (b < 6 && cyc < 30) begin
      beat(8'hB0 + 8'(b), b == 5);
      m_tready = (cyc % 2 == 0) ? 4'b0001 : 4'b0010;
      #1;
      chk("t4_tready_mirror", 32'(s_tready), 32'(m_tready[1]));
      chk("t4_dport", 32'(m_dest_port), 32'h5678);
      if (m_tvalid[1] && m_tready[1]) begin
        exp_d = 8'hB0 + 8'(rx);
        chk("t4_rx_data", 32'(m_tdata), 32'(exp_d));
        rx++;
      end
      tick();
      if (s_tvalid && m_tready[1]) b++;
      cyc++;
    end
    idle_stream();
    m_tready = '0;
    #1;
    chk("t4_rx_count", 32'(rx), 32'd6);
    chk("t4_busy_end", 32'(busy), 32'd0);

    // Back-to-back: next header waits one cycle after tlast
    send_hdr(16'h1234, 16'h4444);
    m_hdr_ready = 4'b0001;
    tick();
    m_hdr_ready = '0;
    beat(8'hC0, 1'b1);
    m_tready = 4'b0001;
    s_hdr_valid = 1'b1;
    s_dest_port = 16'h5678;
    s_source_port = 16'h5555;
    #1;
    chk("t5_ready_on_last", 32'(s_hdr_ready), 32'd0);
    tick();
    idle_stream();
    m_tready = '0;
    #1;
    chk("t5_ready_after", 32'(s_hdr_ready), 32'd1);
    chk("t5_dest_old", 32'(m_dest_port), 32'h1234);
    tick();
    s_hdr_valid = 1'b0;
    #1;
    chk("t5_route", 32'(m_hdr_valid), 32'b0010);
    chk("t5_sport", 32'(m_source_port), 32'h5555);
    m_hdr_ready = 4'b0010;
    tick();
    m_hdr_ready = '0;
    beat(8'hC1, 1'b1);
    m_tready = 4'b0010;
    tick();
    idle_stream();
    m_tready = '0;
    #1;
    chk("t5_busy_end", 32'(busy), 32'd0);

    // Reset during beat 2 of 5
    chk("t6_drop_pre", drop_count, 32'd1);
    send_hdr(16'h5678, 16'h6666);
    m_hdr_ready = 4'b0010;
    tick();
    m_hdr_ready = '0;
    m_tready = 4'b0010;
    beat(8'hD0, 1'b0);
    tick();
    beat(8'hD1, 1'b0);
    tick();
    beat(8'hD2, 1'b0);
    #1;
    chk("t6_tvalid_pre", 32'(m_tvalid), 32'b0010);
    reset = 1'b1;
    #1;
    chk("t6_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_tready", 32'(s_tready), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_drop", drop_count, 32'd0);
    chk("t6_dest", 32'(m_dest_port), 32'd0);
    tick();
    reset = 1'b0;
    idle_stream();
    m_tready = '0;
    #1;
    chk("t6_hdr_ready", 32'(s_hdr_ready), 32'd1);
    chk("t6_hdr_valid", 32'(m_hdr_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_rx_port_dispatch.md
Name: udp_rx_port_dispatch

Overview:
- Sits between the UDP RX stack (header handshake plus payload byte stream) and N user-logic consumers.
- Latches each received UDP header and selects one sink by matching the UDP destination port against a runtime-configured port table.
- Presents the header, then forwards the payload, to that sink only.
- Packets with no matching port are consumed and counted as drops, so the RX stack never stalls on an unclaimed port.

Parameters:
- N_SINKS, 4, number of consumers / port-table entries (1..16).
- DATA_WIDTH, 8, payload stream width in bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_hdr_valid  in  1  upstream header valid
- s_hdr_ready  out  1  upstream header ready
- s_ip_source_ip  in  32  sender IP
- s_source_port  in  16  UDP source port
- s_dest_port  in  16  UDP destination port (match key)
- s_length  in  16  UDP length field
- s_tdata  in  DATA_WIDTH  upstream payload data
- s_tvalid  in  1  upstream payload valid
- s_tlast  in  1  last payload beat of the packet
- s_tready  out  1  upstream payload ready
- cfg_port  in  16*N_SINKS  port table; entry i = bits [16i+15:16i]
- cfg_enable  in  N_SINKS  per-entry enable
- m_hdr_valid  out  N_SINKS  per-sink header valid
- m_hdr_ready  in  N_SINKS  per-sink header ready
- m_ip_source_ip  out  32  latched sender IP, shared by all sinks
- m_source_port  out  16  latched UDP source port, shared
- m_dest_port  out  16  latched UDP destination port, shared
- m_length  out  16  latched UDP length, shared
- m_tdata  out  DATA_WIDTH  payload data, shared
- m_tvalid  out  N_SINKS  per-sink payload valid
- m_tlast  out  1  payload last, shared
- m_tready  in  N_SINKS  per-sink payload ready
- drop_count  out  32  count of unmatched packets, saturating
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - FSM = IDLE; s_hdr_ready = 1.
  - All m_hdr_valid, m_tvalid = 0; s_tready = 0.
  - Latched header fields = 0; drop_count = 0; busy = 0.
- FSM states: IDLE, HDR, PAYLOAD, DROP.
- IDLE:
  - s_hdr_ready = 1.
  - On s_hdr_valid && s_hdr_ready (cycle T):
    - latch the four header fields;
    - compute the match from cfg_port/cfg_enable sampled at T; config changes later in the packet have no effect on it;
    - latch the selected index sel.
  - Match rule: lowest index i with cfg_enable[i] && cfg_port[i] == s_dest_port wins.
  - Next state: HDR if matched, else DROP.
- HDR:
  - m_hdr_valid[sel] = 1 from cycle T+1 (1-cycle latency); all other bits 0.
  - Header fields are held stable.
  - On m_hdr_ready[sel]: go to PAYLOAD; m_hdr_valid drops the next cycle.
  - s_hdr_ready = 0 and s_tready = 0 throughout.
- PAYLOAD (combinational pass-through, zero latency):
  - m_tvalid[sel] = s_tvalid; s_tready = m_tready[sel].
  - m_tdata = s_tdata; m_tlast = s_tlast.
  - Non-selected m_tvalid = 0; their m_tready are ignored.
  - On a beat with s_tvalid && s_tready && s_tlast: go to IDLE.
- DROP:
  - s_tready = 1; all m_tvalid = 0.
  - On an accepted beat with s_tlast: drop_count += 1 (saturates at 0xFFFFFFFF) and go to IDLE.
- Header fields remain valid after HDR until the next header is accepted.
- s_hdr_ready is low from T+1 until the cycle after the last beat; the next header can therefore be accepted at the earliest 1 cycle after tlast.
- Beats arriving while in HDR are held upstream (s_tready = 0); none is lost.
- Zero-length payloads: upstream always sends at least one beat with tlast. The dispatcher requires a tlast beat to leave PAYLOAD/DROP.
- Duplicate table entries: the lowest index wins; no error is flagged.
- A disabled entry never matches, even when its port value matches.
- cfg_port value 0 is legal and matches dest_port 0.
- Reset asserted mid-packet:
  - immediate return to IDLE with all outputs at reset values;
  - the remainder of the in-flight upstream packet is not flushed (upstream is reset together with this block);
  - drop_count clears.
- busy = (state != IDLE).

Test Plan:
- Single match:
  - Stimulus: cfg_port = {0x1234@0, 0x5678@1}, cfg_enable = 0b0011; header dest_port 0x5678 then 4 payload beats 0xA0..0xA3, tlast on the last.
  - Response: m_hdr_valid = 0b0010 at T+1; sink 1 receives 0xA0..0xA3 with m_tlast on 0xA3; sink 0 sees no valid; drop_count = 0.
- Unmatched:
  - Stimulus: dest_port 0x9999, 3 beats.
  - Response: all m_hdr_valid/m_tvalid stay 0; s_tready = 1 for all 3 beats; drop_count = 1; busy falls after tlast.
- Priority and enable:
  - Stimulus: entries 0 and 2 both 0x0050, cfg_enable = 0b0101 → dest_port 0x0050.
  - Response: sink 0 selected.
  - Stimulus: repeat with cfg_enable = 0b0100.
  - Response: sink 2 selected.
- Backpressure:
  - Stimulus: m_hdr_ready[1] held low 5 cycles; then m_tready[1] toggling every other cycle over 6 beats.
  - Response: header fields stable throughout; s_tready mirrors m_tready[1]; no beat duplicated or lost.
- Back-to-back packets:
  - Stimulus: second header valid during the first packet's tlast beat.
  - Response: second header accepted exactly 1 cycle after tlast; routed per its own dest_port.
- Reset mid-payload:
  - Stimulus: assert reset during beat 2 of 5.
  - Response: same-cycle asynchronous clear; m_tvalid = 0; s_hdr_ready = 1 after reset release; drop_count = 0.
